// File: rtl/awg_wave_core_if.sv
// Control and sample bundle for the waveform core: the master drives control, the slave
// returns the registered DAC word.
interface awg_wave_core_if #(
   parameter int unsigned DATA_W = 14,
   parameter int unsigned ACC_W  = 24
);
   logic              en;
   logic [1:0]        sel;
   logic [ACC_W-1:0]  freq;
   logic [3:0]        amp;
   logic [7:0]        phase;
   logic [DATA_W-1:0] dac_data;

   modport master (output en, sel, freq, amp, phase, input dac_data);
   modport slave  (input en, sel, freq, amp, phase, output dac_data);
endinterface

// File: rtl/awg_wave_core.sv
// DDS waveform core: saw, quarter-table sine, LFSR noise or midscale, with 2^-amp attenuation.
// Define AWG_NOISE_EN to build the LFSR noise source; otherwise sel=2 outputs midscale.
module awg_wave_core #(
   parameter int unsigned DATA_W = 14,
   parameter int unsigned ACC_W  = 24
) (
   input logic        clk,
   input logic        rst_n,
   awg_wave_core_if.slave bus
);

   localparam int unsigned QW = 13;
   localparam int unsigned QN = 64;
   localparam logic [DATA_W-1:0] Mid   = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic [DATA_W-1:0] MidM1 = {1'b0, {(DATA_W-1){1'b1}}};
   localparam longint PiQ30 = 64'sd3373259426;

   // Quarter-wave table built at elaboration with fixed-point Taylor series (Q30).
   function automatic logic [QN*QW-1:0] gen_quarter();
      logic [QN*QW-1:0] tab;
      longint x, x2, term, sum;
      tab = '0;
      for (int i = 0; i < QN; i++) begin
         x    = (PiQ30 * longint'(2 * i + 1)) / 64'sd256;
         x2   = (x * x) >>> 30;
         term = x;
         sum  = x;
         for (int k = 1; k < 12; k++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1)));
            sum  = sum + term;
         end
         tab[i*QW +: QW] = QW'((sum * 64'sd8191 + 64'sd536870912) >>> 30);
      end
      return tab;
   endfunction

   localparam logic [QN*QW-1:0] QTab = gen_quarter();

   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [DATA_W-1:0]  dac_q, dac_d;
   logic [DATA_W-1:0]  p14;
   logic [7:0]         p;
   logic [5:0]         jm;
   logic [QW-1:0]      qv;
   logic [DATA_W-1:0]  sine_raw, raw;
   logic [3:0]         a;
   logic signed [DATA_W:0] diff, shifted, scaled;

   assign acc_d = acc_q + bus.freq;
   assign p14   = acc_q[ACC_W-1 -: DATA_W] + {bus.phase, {(DATA_W-8){1'b0}}};
   assign p     = p14[DATA_W-1 -: 8];

   // Odd quadrants read the table mirrored; upper half is reflected below midscale.
   assign jm       = p[6] ? ~p[5:0] : p[5:0];
   assign qv       = QTab[32'(jm) * QW +: QW];
   assign sine_raw = p[7] ? (MidM1 - DATA_W'(qv)) : (Mid + DATA_W'(qv));

`ifdef AWG_NOISE_EN
   logic [15:0] lfsr_q, lfsr_d;
   logic        fb;

   assign fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
   assign lfsr_d = bus.en ? {lfsr_q[14:0], fb} : lfsr_q;

   always_ff @(posedge clk) begin
      if (!rst_n) lfsr_q <= 16'hACE1;
      else        lfsr_q <= lfsr_d;
   end
`endif

   always_comb begin
      raw = Mid;
      unique case (bus.sel)
         2'd0: raw = p14;
         2'd1: raw = sine_raw;
`ifdef AWG_NOISE_EN
         2'd2: raw = lfsr_q[DATA_W-1:0];
`endif
         default: raw = Mid;
      endcase
   end

   // Attenuate around midscale; the arithmetic shift truncates toward minus infinity.
   assign a       = (bus.amp > 4'd9) ? 4'd9 : bus.amp;
   assign diff    = $signed({1'b0, raw}) - $signed({1'b0, Mid});
   assign shifted = diff >>> a;
   assign scaled  = shifted + $signed({1'b0, Mid});
   assign dac_d   = DATA_W'(scaled);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q <= '0;
         dac_q <= Mid;
      end else if (bus.en) begin
         acc_q <= acc_d;
         dac_q <= dac_d;
      end
   end

   assign bus.dac_data = dac_q;

endmodule

// File: tb/tb_awg_wave_core.sv
// Bench for awg_wave_core: directed literal points plus randomized traffic against a
// real-arithmetic waveform model.
module tb_awg_wave_core;

   localparam real PI = 3.14159265358979323846;

   logic clk = 1'b0;
   logic rst_n;

   awg_wave_core_if #(.DATA_W(14), .ACC_W(24)) bus ();

   awg_wave_core #(.DATA_W(14), .ACC_W(24)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int m_acc   = 0;
   int m_lfsr  = 'hACE1;
   int m_dac   = 8192;
   bit chk_on  = 1'b0;

   function automatic int sine_val(int p);
      real s;
      s = $sin(PI * (real'(p) + 0.5) / 128.0);
      if (s >= 0.0) return 8192 + $rtoi(8191.0 * s + 0.5);
      else          return 8191 - $rtoi(-8191.0 * s + 0.5);
   endfunction

   function automatic int scale(int raw, int amp);
      int a, d, dv, s;
      a  = (amp > 9) ? 9 : amp;
      d  = raw - 8192;
      dv = 1 << a;
      s  = (d >= 0) ? d / dv : -((-d + dv - 1) / dv);
      return 8192 + s;
   endfunction

   function automatic int lfsr_next(int l);
      int fb;
      fb = ((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1;
      return ((l << 1) | fb) & 'hFFFF;
   endfunction

   function automatic int sample(int acc, int lfsr, int sel, int amp, int phase);
      int p14, raw;
      p14 = ((acc >> 10) + phase * 64) % 16384;
      case (sel)
         0: raw = p14;
         1: raw = sine_val(p14 / 64);
`ifdef AWG_NOISE_EN
         2: raw = lfsr & 16383;
`endif
         default: raw = 8192;
      endcase
      return scale(raw, amp);
   endfunction

   task automatic model_edge();
      if (!rst_n) begin
         m_acc  = 0;
         m_lfsr = 'hACE1;
         m_dac  = 8192;
      end else if (bus.en) begin
         m_dac  = sample(m_acc, m_lfsr, int'(bus.sel), int'(bus.amp), int'(bus.phase));
         m_acc  = (m_acc + int'(bus.freq)) & 'hFFFFFF;
         m_lfsr = lfsr_next(m_lfsr);
      end
   endtask

   task automatic step(int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_edge();
         @(negedge clk);
      end
   endtask

   task automatic lit(string name, int exp);
      n_tests++;
      if (bus.dac_data !== 14'(exp)) begin
         n_fail++;
         $display("FAIL %s: dac_data=%0d expected %0d", name, bus.dac_data, exp);
      end
      n_tests++;
      if (m_dac != exp) begin
         n_fail++;
         $display("FAIL %s (model): model=%0d expected %0d", name, m_dac, exp);
      end
   endtask

   task automatic drive(bit e, int s, int f, int am, int ph);
      bus.en    = e;
      bus.sel   = 2'(s);
      bus.freq  = 24'(f);
      bus.amp   = 4'(am);
      bus.phase = 8'(ph);
   endtask

   // Every cycle after the first reset edge, the DUT must track the model.
   always @(negedge clk) begin
      if (chk_on) begin
         n_tests++;
         if (bus.dac_data !== 14'(m_dac)) begin
            n_fail++;
            $display("FAIL model dac_data: got %0d expected %0d at %0t", bus.dac_data, m_dac,
                     $time);
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      drive(1, 0, 0, 0, 0);
      step(1);
      chk_on = 1'b1;

      // Reset dominance, then first sample at acc=0
      step(2);
      lit("reset_midscale", 8192);
      rst_n = 1'b1;
      step(1);
      lit("release_saw0", 0);

      // Saw ramp, freeze and wrap
      rst_n = 1'b0;
      drive(1, 0, 1024, 0, 0);
      step(1);
      lit("saw_reset", 8192);
      rst_n = 1'b1;
      step(1);
      lit("saw_0", 0);
      step(1);
      lit("saw_1", 1);
      step(1);
      lit("saw_2", 2);
      bus.en = 1'b0;
      step(5);
      lit("saw_freeze", 2);
      bus.en = 1'b1;
      step(16381);
      lit("saw_top", 16383);
      step(1);
      lit("saw_wrap", 0);

      // Sine quadrant anchors
      rst_n = 1'b0;
      drive(1, 1, 65536, 0, 0);
      step(1);
      rst_n = 1'b1;
      step(1);
      lit("sine_p0", 8293);
      step(64);
      lit("sine_p64", 16382);
      step(64);
      lit("sine_p128", 8090);
      step(64);
      lit("sine_p192", 1);

      // Attenuation and midscale constant
      rst_n = 1'b0;
      drive(1, 0, 0, 0, 0);
      step(1);
      rst_n = 1'b1;
      step(1);
      lit("amp0", 0);
      bus.amp = 4'd1;
      step(1);
      lit("amp1", 4096);
      bus.amp = 4'd9;
      step(1);
      lit("amp9", 8176);
      bus.amp = 4'd15;
      step(1);
      lit("amp15_clamp", 8176);
      bus.sel = 2'd3;
      step(1);
      lit("sel3_amp15", 8192);
      bus.amp = 4'd0;
      step(1);
      lit("sel3_amp0", 8192);

      // Noise source
      rst_n = 1'b0;
      drive(1, 2, 0, 0, 0);
      step(1);
      rst_n = 1'b1;
      step(1);
`ifdef AWG_NOISE_EN
      lit("noise_first", 11489);
      step(1);
      lit("noise_second", 6595);
`else
      lit("noise_off_first", 8192);
      step(1);
      lit("noise_off_second", 8192);
`endif

      // Phase offset
      rst_n = 1'b0;
      drive(1, 1, 0, 0, 64);
      step(1);
      rst_n = 1'b1;
      step(1);
      lit("phase64", 16382);

      // Randomized traffic with occasional mid-run resets
      for (int c = 0; c < 3000; c++) begin
         rst_n  = ($urandom_range(0, 99) != 0);
         bus.en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) bus.sel = 2'($urandom);
         if ($urandom_range(0, 7) == 0) bus.amp = 4'($urandom);
         if ($urandom_range(0, 7) == 0) bus.phase = 8'($urandom);
         if ($urandom_range(0, 15) == 0)
            bus.freq = ($urandom_range(0, 1) == 0) ? 24'($urandom_range(0, 4096))
                                                    : 24'($urandom);
         step(1);
      end

      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/awg_wave_core.md
AWG_WAVE_CORE -- requirements
Module: awg_wave_core

Interface
REQ-001 Parameter DATA_W, 14, DAC word width; offset-binary output, midscale 8192.
REQ-002 Parameter ACC_W, 24, phase accumulator width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 en  input  1  advance enable; 1 = accumulator, LFSR and output register update this cycle.
REQ-006 sel  input  2  waveform select: 0 saw, 1 sine, 2 noise, 3 midscale constant.
REQ-007 freq  input  24  phase increment per enabled cycle.
REQ-008 amp  input  4  attenuation exponent; gain 2^-amp, values above 9 treated as 9.
REQ-009 phase  input  8  phase offset, 1/256 cycle per LSB.
REQ-010 dac_data  output  14  registered DAC sample.

Function
REQ-011 Accumulator acc (24 bit) SHALL load acc + freq modulo 2^24 on every enabled cycle and hold when en=0.
REQ-012 Phase word p14 SHALL equal (acc[23:10] + {phase, 6'b0}) mod 2^14; sine index p = p14[13:6].
REQ-013 Saw raw value SHALL equal p14; wraps 16383 -> 0 with no glitch value.
REQ-014 Sine SHALL use a 64-entry quarter table q[i] = round(8191*sin(pi*(i+0.5)/128)), i = 0..63.
REQ-015 Sine raw, with j = p[5:0]: quadrant p[7:6]=0 -> 8192+q[j]; 1 -> 8192+q[63-j]; 2 -> 8191-q[j]; 3 -> 8191-q[63-j]; range 0..16383.
REQ-016 Noise: 16-bit Fibonacci LFSR, feedback = b15^b13^b12^b10, next = {lfsr[14:0], feedback}, shifts on every enabled cycle; noise raw = lfsr[13:0].
REQ-017 Scaling: out = 8192 + ((raw - 8192) arithmetic-right-shift a), where a = min(amp, 9) and the difference is 15-bit signed; no rounding.
REQ-018 sel=3 SHALL yield 8192 regardless of amp.
REQ-019 On an enabled edge, dac_data SHALL load the scaled sample computed from the pre-update acc and lfsr; one-cycle latency, accumulator and output advance together.
REQ-020 With en=0, dac_data, acc and lfsr SHALL hold.
REQ-021 Changes to sel, amp, phase or freq SHALL take effect on the next enabled edge, with no pipeline flush and no phase reset.

Reset
REQ-022 While rst_n=0 at a rising edge: acc <= 0, lfsr <= 16'hACE1, dac_data <= 8192; takes priority over en.
REQ-023 Reset mid-operation SHALL discard the accumulated phase; the first enabled edge after release outputs the waveform at acc=0.

Configuration
REQ-024 Macro AWG_NOISE_EN defined: LFSR and noise path present per REQ-016.
REQ-025 Macro AWG_NOISE_EN undefined: LFSR omitted and sel=2 SHALL behave as sel=3 (dac_data 8192); all other behaviour unchanged.

Verification
REQ-026 Reset held, then release with en=1, sel=0, freq=0, phase=0, amp=0 -> dac_data 8192 during reset, then 0.
REQ-027 Saw, freq=1024, phase=0, amp=0 -> dac_data 0,1,2,... per enabled cycle; 16383 followed by 0; en=0 for 5 cycles freezes the value.
REQ-028 Sine, freq=65536, amp=0 -> p=0: 8293; p=64: 16382; p=128: 8090; p=192: 1.
REQ-029 Saw, freq=0, phase=0 -> amp=1: 4096; amp=9: 8176; amp=15: 8176; sel=3 with any amp: 8192.
REQ-030 Noise (AWG_NOISE_EN defined), sel=2, amp=0 after reset -> first sample 11489 (0x2CE1), second 6595 (0x19C3); undefined build -> 8192.
REQ-031 Phase offset, sel=1, freq=0, phase=64 -> 16382, equal to the sample at p=64 with phase=0.
